// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants and entry type for the instruction fetch
//                unit and its small queues.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int PC_W_DEF     = 10;
    localparam int INSTR_W_DEF  = 32;
    localparam int RESET_PC_DEF = 0;
    localparam int PC_STEP      = 4;
    localparam int FQ_DEPTH     = 2;

    // One decode-bound entry at default widths
    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Entry width for non-default parameterisations of the fetch unit
    function automatic int entry_width(input int pc_w, input int instr_w);
        return pc_w + instr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Two-entry synchronous FIFO with flush and occupancy count.
//                Output is taken straight from storage (no bypass), so data
//                pushed in cycle N is visible in cycle N+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [FQ_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'(FQ_DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full queue is only legal when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; flush empties without touching data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && full && !pop && !flush));

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch unit. Owns the fetch PC, issues credit-
//                limited requests to instruction memory, drops responses made
//                stale by a redirect and hands {pc, instr} to decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [PC_W-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr,
    input  logic               if_ready
);

    localparam int          EW       = entry_width(PC_W, INSTR_W);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
    localparam logic [PC_W-1:0] START_PC   = PC_W'(RESET_PC) & ALIGN_MASK;

    logic [PC_W-1:0] fetch_pc;
    logic [1:0]      outstanding;
    logic [1:0]      discard;
    logic [1:0]      fifo_count;
    logic [1:0]      tag_count;
    logic [PC_W-1:0] tag_pc;
    logic [EW-1:0]   fifo_dout;
    logic [PC_W-1:0] redirect_target;
    logic [2:0]      in_use;
    logic            pop;
    logic            gnt_acc;
    logic            push_resp;

    assign redirect_target = redirect_pc & ALIGN_MASK;
    assign pop             = if_valid && if_ready;

    // Slots already committed: in-flight requests plus buffered entries, less the one leaving now
    assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count} - {2'b00, pop};
    assign imem_req  = (in_use < 3'd2) && !redirect_valid && rst;
    assign imem_addr = fetch_pc;
    assign gnt_acc   = imem_req && imem_gnt;

    // Responses reach the queue only when nothing stale is still ahead of them
    assign push_resp = imem_rvalid && (discard == 2'd0) && !redirect_valid;

    assign if_valid = (fifo_count != 2'd0);
    assign if_pc    = fifo_dout[EW-1 -: PC_W];
    assign if_instr = fifo_dout[INSTR_W-1:0];

    // Fetch PC, in-flight count and stale-response count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= START_PC;
            outstanding <= 2'd0;
            discard     <= 2'd0;
        end else begin
            outstanding <= outstanding + {1'b0, gnt_acc} - {1'b0, imem_rvalid};
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                // Everything still in flight after this cycle belongs to the old path
                discard  <= outstanding - {1'b0, imem_rvalid};
            end else begin
                if (gnt_acc) begin
                    fetch_pc <= fetch_pc + PC_W'(PC_STEP);
                end
                if (imem_rvalid && (discard != 2'd0)) begin
                    discard <= discard - 2'd1;
                end
            end
        end
    end

    // In-order address tags for granted requests; stale ones retire with their response
    fetch_fifo #(
        .WIDTH (PC_W)
    ) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (gnt_acc),
        .pop   (imem_rvalid),
        .din   (fetch_pc),
        .dout  (tag_pc),
        .count (tag_count)
    );

    // Decode-facing instruction queue, emptied on redirect
    fetch_fifo #(
        .WIDTH (EW)
    ) u_instr_q (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push_resp),
        .pop   (pop),
        .din   ({tag_pc, imem_rdata}),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    a_tags_track_outstanding: assert property (@(posedge clk) disable iff (!rst)
        tag_count == outstanding);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch: in-order memory model
//                with variable latency, random grant/ready/redirect, and a
//                path-tagged reference of the decode stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [9:0]  redirect_pc = '0;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [9:0]  if_pc;
    logic [31:0] if_instr;
    logic        if_ready = 1'b0;

    instr_fetch #(
        .PC_W     (10),
        .INSTR_W  (32),
        .RESET_PC (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [9:0] addr; int path; int due; } mreq_t;
    typedef struct { logic [9:0] pc; logic [31:0] instr; } ent_t;

    mreq_t      memq[$];     // granted requests awaiting a response
    ent_t       modelq[$];   // instructions decode should still see, in order
    logic [9:0] exp_fetch = '0;
    int         path = 0;    // bumps on every redirect/reset: older requests are stale
    int         cyc = 0;
    int         last_due = -1;
    int         n_vec = 0;
    int         n_err = 0;
    int         n_gnt = 0;
    int         first_valid_cyc = -1;
    int         ready_pct = 100;
    int         gnt_pct = 100;
    int         lat_min = 1;
    int         lat_max = 1;
    int         redir_pct = 0;
    bit         release_now = 1'b0;
    bit         obs_valid;
    bit         obs_xfer;
    logic [9:0] obs_pc;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return ({a, 22'h0} ^ (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        memq.delete();
        modelq.delete();
        path++;
        exp_fetch = 10'h000;
        last_due = -1;
    endtask

    // One clock cycle: drive inputs, check outputs in the low phase, advance the model
    task automatic run_cycle(input bit redir, input logic [9:0] rpc);
        bit   rv;
        bit   xfer;
        bit   exp_req;
        int   used;
        int   due;
        mreq_t r;
        @(negedge clk);
        if (release_now) begin
            rst = 1'b1;
            release_now = 1'b0;
            cyc = 0;
            first_valid_cyc = -1;
        end
        redirect_valid = redir;
        redirect_pc    = rpc;
        if_ready = ($urandom_range(99) < ready_pct);
        imem_gnt = ($urandom_range(99) < gnt_pct);
        rv = (memq.size() != 0) && (memq[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(memq[0].addr) : $urandom;
        #1;
        obs_valid = if_valid;
        obs_pc    = if_pc;
        if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

        chk("if_valid", 64'(if_valid), 64'(modelq.size() != 0));
        if (if_valid && modelq.size() != 0) begin
            chk("if_pc", 64'(if_pc), 64'(modelq[0].pc));
            chk("if_instr", 64'(if_instr), 64'(modelq[0].instr));
        end
        xfer = (modelq.size() != 0) && if_ready;
        obs_xfer = xfer;
        used = memq.size() + modelq.size() - (xfer ? 1 : 0);
        exp_req = !redir && (used < 2);
        chk("imem_req", 64'(imem_req), 64'(exp_req));
        if (imem_req) chk("imem_addr", 64'(imem_addr), 64'(exp_fetch));

        if (xfer) void'(modelq.pop_front());
        if (redir) begin
            path++;
            modelq.delete();
            exp_fetch = rpc & 10'h3FC;
        end
        if (rv) begin
            r = memq.pop_front();
            if (r.path == path) modelq.push_back('{pc: r.addr, instr: mem_word(r.addr)});
        end
        if (imem_req && imem_gnt) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{addr: imem_addr, path: path, due: due});
            exp_fetch = exp_fetch + 10'd4;
            n_gnt++;
        end
        chk("occupancy", 64'((memq.size() + modelq.size()) <= 2), 64'(1));
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 10'h0);
    endtask

    // Run until the next valid instruction and compare its address
    task automatic expect_next_pc(input string tag, input logic [9:0] pc);
        bit got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            run_cycle(1'b0, 10'h0);
            if (obs_valid && obs_xfer) begin
                got = 1'b1;
                chk(tag, 64'(obs_pc), 64'(pc));
            end
        end
        if (!got) chk({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    initial begin
        int g0;
        logic [9:0] pc0;
        bit found;

        // Reset values
        #1;
        chk("rst_req", 64'(imem_req), 64'(0));
        chk("rst_valid", 64'(if_valid), 64'(0));
        chk("rst_pc", 64'(if_pc), 64'(0));
        chk("rst_instr", 64'(if_instr), 64'(0));
        model_reset();
        @(negedge clk);
        release_now = 1'b1;

        // Streaming at one instruction per cycle
        ready_pct = 100; gnt_pct = 100; lat_min = 1; lat_max = 1;
        idle(20);
        chk("first_valid_cycle", 64'(first_valid_cyc), 64'(2));

        // Backpressure for five cycles
        ready_pct = 0;
        g0 = n_gnt;
        run_cycle(1'b0, 10'h0);
        pc0 = obs_pc;
        idle(4);
        chk("hold_pc", 64'(obs_pc), 64'(pc0));
        chk("hold_valid", 64'(obs_valid), 64'(1));
        chk("hold_grants_le2", 64'((n_gnt - g0) <= 2), 64'(1));
        ready_pct = 100;
        idle(6);

        // Latency 3: redirect with two requests in flight
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (memq.size() == 2) found = 1'b1;
            else run_cycle(1'b0, 10'h0);
        end
        chk("two_outstanding", 64'(memq.size()), 64'(2));
        run_cycle(1'b1, 10'h100);
        expect_next_pc("redir_0x100", 10'h100);
        idle(4);

        // Redirect landing on a live response
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (memq.size() != 0 && memq[0].due <= cyc && memq[0].path == path) found = 1'b1;
            else run_cycle(1'b0, 10'h0);
        end
        chk("rvalid_for_redirect", 64'(found), 64'(1));
        run_cycle(1'b1, 10'h106);
        expect_next_pc("redir_0x106", 10'h104);
        idle(4);

        // Address wrap
        lat_min = 1; lat_max = 1;
        run_cycle(1'b1, 10'h3F8);
        expect_next_pc("wrap_0", 10'h3F8);
        expect_next_pc("wrap_1", 10'h3FC);
        expect_next_pc("wrap_2", 10'h000);

        // Random traffic
        ready_pct = 70; gnt_pct = 75; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 5) run_cycle(1'b1, 10'($urandom_range(1023)));
            else run_cycle(1'b0, 10'h0);
        end

        // Asynchronous reset with the queue full
        ready_pct = 0; gnt_pct = 100; lat_min = 1; lat_max = 1;
        idle(3);
        for (int i = 0; i < 20 && modelq.size() != 2; i++) run_cycle(1'b0, 10'h0);
        chk("full_before_reset", 64'(modelq.size()), 64'(2));
        @(negedge clk);
        imem_rvalid = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_rst_req", 64'(imem_req), 64'(0));
        chk("async_rst_valid", 64'(if_valid), 64'(0));
        chk("async_rst_pc", 64'(if_pc), 64'(0));
        model_reset();
        @(negedge clk);
        release_now = 1'b1;
        ready_pct = 100;
        idle(12);
        chk("restart_first_valid", 64'(first_valid_cyc), 64'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
